// File: rtl/mips32_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips32_mem_pkg
// Purpose  : Shared types and defaults for the MIPS32 unified-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mips32_mem_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2,
    OWN_DBG  = 2'd3
  } own_e;

  localparam int AW_DEF = 10;
  localparam int DW_DEF = 32;

endpackage
`default_nettype wire

// File: rtl/mips32_starve_ctr.sv
`default_nettype none
// ============================================================================
// Module   : mips32_starve_ctr
// Purpose  : Saturating count of consecutive IF denials; o_sat at STARVE_MAX.
// Revision : 1.0 - initial release
// ============================================================================
module mips32_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_sat
);

  localparam int             CW    = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0]  c_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] r_cnt;
  logic          w_sat;

  assign w_sat = (r_cnt == c_MAX);
  assign o_sat = w_sat;

  // Clear takes precedence so a grant to IF always restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !w_sat) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mips32_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mips32_mem_arbiter
// Purpose  : Single-port memory arbiter for IF / LS (and optional debug port,
//            enabled by defining DBG_PORT_EN). Combinational grant, tagged
//            one-cycle read response.
// Revision : 1.0 - initial release
// ============================================================================
module mips32_mem_arbiter
  import mips32_mem_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_halted,
  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_addr,
  output logic          o_if_gnt,
  output logic          o_if_rvalid,
  output logic [DW-1:0] o_if_rdata,
  input  logic          i_ls_req,
  input  logic          i_ls_we,
  input  logic [AW-1:0] i_ls_addr,
  input  logic [DW-1:0] i_ls_wdata,
  output logic          o_ls_gnt,
  output logic          o_ls_rvalid,
  output logic [DW-1:0] o_ls_rdata,
`ifdef DBG_PORT_EN
  input  logic          i_dbg_req,
  input  logic          i_dbg_we,
  input  logic [AW-1:0] i_dbg_addr,
  input  logic [DW-1:0] i_dbg_wdata,
  output logic          o_dbg_gnt,
  output logic          o_dbg_rvalid,
  output logic [DW-1:0] o_dbg_rdata,
`endif
  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata
);

  logic w_if_elig;
  logic w_ls_elig;
  logic w_sat;
  logic w_dbg_gnt;
  logic w_if_gnt;
  logic w_ls_gnt;
  own_e w_owner_nxt;
  own_e r_resp_owner;

  // Grants are masked by rst_n so every output reads 0 while reset is held.
`ifdef DBG_PORT_EN
  assign w_dbg_gnt = rst_n & i_dbg_req;
`else
  assign w_dbg_gnt = 1'b0;
`endif

  assign w_if_elig = rst_n & i_if_req & ~i_halted;
  assign w_ls_elig = rst_n & i_ls_req;
  assign w_if_gnt  = ~w_dbg_gnt & w_if_elig & (~w_ls_elig | w_sat);
  assign w_ls_gnt  = ~w_dbg_gnt & w_ls_elig & ~w_if_gnt;

  assign o_if_gnt  = w_if_gnt;
  assign o_ls_gnt  = w_ls_gnt;

  // A debug grant neither increments nor clears the count: IF keeps its place.
  mips32_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_if_elig & w_ls_gnt),
    .i_clr (w_if_gnt | ~w_if_elig),
    .o_sat (w_sat)
  );

  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    w_owner_nxt = OWN_NONE;
`ifdef DBG_PORT_EN
    if (w_dbg_gnt) begin
      o_mem_en    = 1'b1;
      o_mem_we    = i_dbg_we;
      o_mem_addr  = i_dbg_addr;
      o_mem_wdata = i_dbg_we ? i_dbg_wdata : '0;
      w_owner_nxt = i_dbg_we ? OWN_NONE : OWN_DBG;
    end else
`endif
    if (w_if_gnt) begin
      o_mem_en    = 1'b1;
      o_mem_addr  = i_if_addr;
      w_owner_nxt = OWN_IF;
    end else if (w_ls_gnt) begin
      o_mem_en    = 1'b1;
      o_mem_we    = i_ls_we;
      o_mem_addr  = i_ls_addr;
      o_mem_wdata = i_ls_we ? i_ls_wdata : '0;
      w_owner_nxt = i_ls_we ? OWN_NONE : OWN_LS;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_owner <= OWN_NONE;
    end else begin
      r_resp_owner <= w_owner_nxt;
    end
  end

  assign o_if_rvalid = (r_resp_owner == OWN_IF);
  assign o_ls_rvalid = (r_resp_owner == OWN_LS);
  assign o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
  assign o_ls_rdata  = o_ls_rvalid ? i_mem_rdata : '0;

`ifdef DBG_PORT_EN
  assign o_dbg_gnt    = w_dbg_gnt;
  assign o_dbg_rvalid = (r_resp_owner == OWN_DBG);
  assign o_dbg_rdata  = o_dbg_rvalid ? i_mem_rdata : '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mips32_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips32_mem_arbiter
// Purpose  : Self-checking bench for mips32_mem_arbiter with a behavioural
//            memory and a randomized arbitration reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips32_mem_arbiter;

    localparam int AW         = 10;
    localparam int DW         = 32;
    localparam int STARVE_MAX = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          halted;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt, if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          ls_req, ls_we;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata;
    logic          ls_gnt, ls_rvalid;
    logic [DW-1:0] ls_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
`ifdef DBG_PORT_EN
    logic          dbg_req, dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_gnt, dbg_rvalid;
    logic [DW-1:0] dbg_rdata;
`endif

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] prog [0:3];

    always #5 clk = ~clk;

    mips32_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_halted    (halted),
        .i_if_req    (if_req),
        .i_if_addr   (if_addr),
        .o_if_gnt    (if_gnt),
        .o_if_rvalid (if_rvalid),
        .o_if_rdata  (if_rdata),
        .i_ls_req    (ls_req),
        .i_ls_we     (ls_we),
        .i_ls_addr   (ls_addr),
        .i_ls_wdata  (ls_wdata),
        .o_ls_gnt    (ls_gnt),
        .o_ls_rvalid (ls_rvalid),
        .o_ls_rdata  (ls_rdata),
`ifdef DBG_PORT_EN
        .i_dbg_req   (dbg_req),
        .i_dbg_we    (dbg_we),
        .i_dbg_addr  (dbg_addr),
        .i_dbg_wdata (dbg_wdata),
        .o_dbg_gnt   (dbg_gnt),
        .o_dbg_rvalid(dbg_rvalid),
        .o_dbg_rdata (dbg_rdata),
`endif
        .o_mem_en    (mem_en),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata)
    );

    // Single-port synchronous memory; all contents are written through the DUT.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        halted = 1'b0; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
        if_addr = '0; ls_addr = '0; ls_wdata = '0;
`ifdef DBG_PORT_EN
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
`endif
    endtask

    task automatic ls_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        next_cycle();
        idle_inputs();
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = a; ls_wdata = d;
        #3;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0; if_req = 1'b1; ls_req = 1'b1; ls_addr = 10'd77; if_addr = 10'd5;
        ls_wdata = 32'hDEADBEEF;
        #3;
        total++;
        if ({if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_en, mem_we} !== 6'b0 ||
            mem_addr !== '0 || mem_wdata !== '0 || if_rdata !== '0 || ls_rdata !== '0) begin
            bad++;
            $display("FAIL reset_outputs: gnt=%b%b rv=%b%b en=%b we=%b addr=%0d wd=%h required all 0",
                     if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_en, mem_we, mem_addr, mem_wdata);
        end
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        #3;
        total++;
        if (ls_gnt !== 1'b1 || if_gnt !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_first: if_gnt=%b ls_gnt=%b required 0 1", if_gnt, ls_gnt);
        end
    endtask

    task automatic test_if_only();
        prog[0] = 32'h28010078; prog[1] = 32'h20020005;
        prog[2] = 32'h00221820; prog[3] = 32'hAC030079;
        for (int k = 0; k < 4; k++) ls_write(AW'(k), prog[k]);
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            idle_inputs();
            if (k < 4) begin if_req = 1'b1; if_addr = AW'(k); end
            #3;
            if (k < 4) begin
                total++;
                if (if_gnt !== 1'b1 || ls_gnt !== 1'b0 || mem_en !== 1'b1 || mem_we !== 1'b0 ||
                    mem_addr !== AW'(k)) begin
                    bad++;
                    $display("FAIL if_only_gnt[%0d]: if_gnt=%b en=%b addr=%0d required 1 1 %0d",
                             k, if_gnt, mem_en, mem_addr, k);
                end
            end
            if (k > 0) begin
                total++;
                if (if_rvalid !== 1'b1 || if_rdata !== prog[k-1] || ls_rvalid !== 1'b0) begin
                    bad++;
                    $display("FAIL if_only_rdata[%0d]: rvalid=%b rdata=%h required 1 %h",
                             k - 1, if_rvalid, if_rdata, prog[k-1]);
                end
            end
        end
    endtask

    task automatic test_starvation();
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            idle_inputs();
            if_req = 1'b1; ls_req = 1'b1; if_addr = 10'd1; ls_addr = 10'd0;
            #3;
            total++;
            if ({if_gnt, ls_gnt} !== ((k % 5 == 4) ? 2'b10 : 2'b01)) begin
                bad++;
                $display("FAIL starve_pattern[%0d]: if_gnt=%b ls_gnt=%b required IF=%0d",
                         k, if_gnt, ls_gnt, (k % 5 == 4));
            end
        end
    endtask

    task automatic test_ls_write_read();
        ls_write(10'd121, 32'd130);
        total++;
        if (ls_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 10'd121 || mem_wdata !== 32'd130) begin
            bad++;
            $display("FAIL sw_bus: gnt=%b we=%b addr=%0d wd=%0d required 1 1 121 130",
                     ls_gnt, mem_we, mem_addr, mem_wdata);
        end
        next_cycle();
        idle_inputs();
        ls_req = 1'b1; ls_addr = 10'd121;
        #3;
        total++;
        if (ls_rvalid !== 1'b0 || ls_gnt !== 1'b1 || mem_we !== 1'b0) begin
            bad++;
            $display("FAIL sw_no_rvalid: ls_rvalid=%b ls_gnt=%b required 0 1", ls_rvalid, ls_gnt);
        end
        next_cycle();
        idle_inputs();
        #3;
        total++;
        if (ls_rvalid !== 1'b1 || ls_rdata !== 32'd130 || if_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL lw_rdata: ls_rvalid=%b ls_rdata=%0d required 1 130", ls_rvalid, ls_rdata);
        end
    endtask

    task automatic test_halted();
        next_cycle();
        idle_inputs();
        if_req = 1'b1; if_addr = 10'd2;
        #3;
        total++;
        if (if_gnt !== 1'b1) begin
            bad++;
            $display("FAIL halt_pre_gnt: if_gnt=%b required 1", if_gnt);
        end
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            idle_inputs();
            halted = 1'b1; if_req = 1'b1; if_addr = 10'd3;
            #3;
            total++;
            if (if_gnt !== 1'b0 || ls_gnt !== 1'b0 || mem_en !== 1'b0 || mem_addr !== '0) begin
                bad++;
                $display("FAIL halt_no_gnt[%0d]: if_gnt=%b ls_gnt=%b mem_en=%b required 0 0 0",
                         k, if_gnt, ls_gnt, mem_en);
            end
            if (k == 0) begin
                total++;
                if (if_rvalid !== 1'b1 || if_rdata !== prog[2]) begin
                    bad++;
                    $display("FAIL halt_inflight: if_rvalid=%b if_rdata=%h required 1 %h",
                             if_rvalid, if_rdata, prog[2]);
                end
            end
        end
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            idle_inputs();
            if_req = 1'b1; ls_req = 1'b1;
            #3;
            total++;
            if ({if_gnt, ls_gnt} !== ((k == 4) ? 2'b10 : 2'b01)) begin
                bad++;
                $display("FAIL halt_cnt_zero[%0d]: if_gnt=%b ls_gnt=%b required IF=%0d",
                         k, if_gnt, ls_gnt, (k == 4));
            end
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] refm [0:15];
        int            den;
        int            pend;
        int            win;
        logic [DW-1:0] pdata;
        logic          ife;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_wd;
        for (int a = 0; a < 16; a++) begin
            refm[a] = $urandom;
            ls_write(AW'(a), refm[a]);
        end
        next_cycle();
        idle_inputs();
        den = 0; pend = 0; pdata = '0;
        for (int n = 0; n < 400; n++) begin
            next_cycle();
            idle_inputs();
            if_req   = ($urandom_range(0, 3) != 0);
            ls_req   = ($urandom_range(0, 2) != 0);
            halted   = ($urandom_range(0, 9) == 0);
            ls_we    = $urandom_range(0, 1) == 1;
            if_addr  = AW'($urandom_range(0, 15));
            ls_addr  = AW'($urandom_range(0, 15));
            ls_wdata = $urandom;
            #3;
            ife = if_req && !halted;
            if (ife && (!ls_req || den == STARVE_MAX)) win = 1;
            else if (ls_req)                           win = 2;
            else                                       win = 0;
            exp_addr = (win == 1) ? if_addr : (win == 2) ? ls_addr : '0;
            exp_wd   = (win == 2 && ls_we) ? ls_wdata : '0;
            total++;
            if ({if_gnt, ls_gnt} !== {win == 1, win == 2}) begin
                bad++;
                $display("FAIL rand_gnt[%0d]: if_gnt=%b ls_gnt=%b required winner=%0d", n, if_gnt, ls_gnt, win);
            end
            total++;
            if (mem_en !== (win != 0) || mem_we !== (win == 2 && ls_we) ||
                mem_addr !== exp_addr || mem_wdata !== exp_wd) begin
                bad++;
                $display("FAIL rand_bus[%0d]: en=%b we=%b addr=%0d wd=%h required %b %b %0d %h", n,
                         mem_en, mem_we, mem_addr, mem_wdata, win != 0, win == 2 && ls_we, exp_addr, exp_wd);
            end
            total++;
            if (if_rvalid !== (pend == 1) || ls_rvalid !== (pend == 2) ||
                if_rdata !== ((pend == 1) ? pdata : '0) || ls_rdata !== ((pend == 2) ? pdata : '0)) begin
                bad++;
                $display("FAIL rand_resp[%0d]: rv=%b%b if_rd=%h ls_rd=%h required owner=%0d data=%h",
                         n, if_rvalid, ls_rvalid, if_rdata, ls_rdata, pend, pdata);
            end
            pend = 0;
            if (win == 1) begin
                pend = 1; pdata = refm[if_addr[3:0]];
            end else if (win == 2) begin
                if (ls_we) refm[ls_addr[3:0]] = ls_wdata;
                else begin pend = 2; pdata = refm[ls_addr[3:0]]; end
            end
            if (win == 1 || !ife) den = 0;
            else if (den < STARVE_MAX) den = den + 1;
        end
    endtask

    task automatic test_reset_mid();
        next_cycle();
        idle_inputs();
        if_req = 1'b1; if_addr = 10'd0;
        #3;
        total++;
        if (if_gnt !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_gnt: if_gnt=%b required 1", if_gnt);
        end
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_inputs();
        #3;
        total++;
        if (if_rvalid !== 1'b0 || ls_rvalid !== 1'b0 || if_rdata !== '0) begin
            bad++;
            $display("FAIL rstmid_drop: if_rvalid=%b ls_rvalid=%b required 0 0", if_rvalid, ls_rvalid);
        end
    endtask

`ifdef DBG_PORT_EN
    task automatic test_dbg();
        next_cycle();
        idle_inputs();
        if_req = 1'b1; ls_req = 1'b1;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 10'd120; dbg_wdata = 32'd85;
        #3;
        total++;
        if (dbg_gnt !== 1'b1 || if_gnt !== 1'b0 || ls_gnt !== 1'b0 || mem_we !== 1'b1 ||
            mem_addr !== 10'd120 || mem_wdata !== 32'd85) begin
            bad++;
            $display("FAIL dbg_write: dbg=%b if=%b ls=%b we=%b addr=%0d required 1 0 0 1 120",
                     dbg_gnt, if_gnt, ls_gnt, mem_we, mem_addr);
        end
        next_cycle();
        dbg_we = 1'b0; dbg_wdata = '0;
        #3;
        total++;
        if (dbg_gnt !== 1'b1 || dbg_rvalid !== 1'b0 || if_gnt !== 1'b0 || ls_gnt !== 1'b0) begin
            bad++;
            $display("FAIL dbg_read_gnt: dbg_gnt=%b dbg_rvalid=%b required 1 0", dbg_gnt, dbg_rvalid);
        end
        next_cycle();
        idle_inputs();
        #3;
        total++;
        if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'd85 || if_rvalid !== 1'b0 || ls_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL dbg_rdata: dbg_rvalid=%b dbg_rdata=%0d required 1 85", dbg_rvalid, dbg_rdata);
        end
        next_cycle();
        dbg_req = 1'b1; dbg_addr = 10'd120;
        #3;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_inputs();
        #3;
        total++;
        if (dbg_rvalid !== 1'b0 || dbg_rdata !== '0) begin
            bad++;
            $display("FAIL dbg_rstmid: dbg_rvalid=%b required 0", dbg_rvalid);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_if_only();
        test_starvation();
        test_ls_write_read();
        test_halted();
        test_random();
        test_reset_mid();
`ifdef DBG_PORT_EN
        test_dbg();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
